// File: rtl/cap_pkg.sv
// Shared constants for the capture scheduler: FSM encoding, id width and capture timing limits.
package cap_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_SETUP   = 2'd1;
    localparam logic [ST_W-1:0] ST_CAPTURE = 2'd2;
    localparam logic [ST_W-1:0] ST_HOLD    = 2'd3;

    localparam int unsigned GID_W = 3;

    // Timing-check limits on the shared capture register
    localparam int unsigned SETUP_LIMIT = 10;
    localparam int unsigned HOLD_LIMIT  = 10;

endpackage

// File: rtl/capture_scheduler_if.sv
// Requester/capture bus of the capture scheduler; slave side is the scheduler itself.
interface capture_scheduler_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data_in;
    logic [NREQ-1:0]   ack;
    logic [2:0]        grant_id;
    logic              busy;
    logic              cap_en;
    logic [W-1:0]      cap_data;
    logic [W-1:0]      out;
    logic              out_valid;

    modport master (
        output req, data_in,
        input  ack, grant_id, busy, cap_en, cap_data, out, out_valid
    );

    modport slave (
        input  req, data_in,
        output ack, grant_id, busy, cap_en, cap_data, out, out_valid
    );
endinterface

// File: rtl/cap_reg.sv
// Shared W-bit capture register with enable and async active-low reset.
// Optional setup/hold timing checks are compiled in with CAP_TIMING_CHECK_EN.
module cap_reg #(
    parameter int unsigned W = 8
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         cap_en,
    input  logic [W-1:0] cap_data,
    output logic [W-1:0] q
);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (cap_en) begin
            q <= cap_data;
        end
    end

`ifdef CAP_TIMING_CHECK_EN
    import cap_pkg::*;

    specify
        $setup(cap_data, posedge ck &&& cap_en, SETUP_LIMIT);
        $hold(posedge ck &&& cap_en, cap_data, HOLD_LIMIT);
    endspecify
`else
`endif

endmodule

// File: rtl/capture_scheduler.sv
// Round-robin capture scheduler: IDLE->SETUP->CAPTURE->HOLD sequencing into one shared register.
// CAP_TIMING_CHECK_EN enables timing checks inside cap_reg; cycle behaviour is unchanged.
module capture_scheduler
    import cap_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic               ck,
    input  logic               rst_n,
    capture_scheduler_if.slave bus
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [ST_W-1:0]  state, state_d;
    logic [PW-1:0]    ptr, ptr_d;
    logic [GID_W-1:0] grant, grant_d;
    logic [W-1:0]     cap_data, cap_data_d;
    logic             cap_en, cap_en_d;
    logic [NREQ-1:0]  ack, ack_d;
    logic             out_valid, out_valid_d;
    logic             busy, busy_d;
    logic [W-1:0]     out_q;

    logic [NREQ-1:0]  rot_c;
    logic [PW-1:0]    off_c;
    logic [PW:0]      sum_c;
    logic [PW-1:0]    win_c;
    logic             found_c;
    logic [W-1:0]     sel_c;

    // Round-robin search starting at ptr, the requester after the last winner
    always_comb begin
        rot_c   = NREQ'({bus.req, bus.req} >> ptr);
        found_c = 1'b0;
        off_c   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_c && rot_c[i]) begin
                found_c = 1'b1;
                off_c   = PW'(i);
            end
        end
        sum_c = (PW+1)'(ptr) + (PW+1)'(off_c);
        if (sum_c >= (PW+1)'(NREQ)) begin
            sum_c = sum_c - (PW+1)'(NREQ);
        end
        win_c = PW'(sum_c);
    end

    always_comb begin
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win_c) begin
                sel_c = bus.data_in[i*W +: W];
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        grant_d     = grant;
        cap_data_d  = cap_data;
        cap_en_d    = 1'b0;
        ack_d       = '0;
        out_valid_d = 1'b0;

        case (state)
            ST_IDLE: begin
                if (found_c) begin
                    state_d    = ST_SETUP;
                    cap_data_d = sel_c;
                    grant_d    = GID_W'(win_c);
                    ptr_d      = (win_c == PW'(NREQ - 1)) ? '0 : win_c + PW'(1);
                end
            end
            ST_SETUP: begin
                state_d  = ST_CAPTURE;
                cap_en_d = 1'b1;
            end
            ST_CAPTURE: begin
                state_d     = ST_HOLD;
                ack_d       = NREQ'(1) << grant;
                out_valid_d = 1'b1;
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant     <= '0;
            cap_data  <= '0;
            cap_en    <= 1'b0;
            ack       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            grant     <= grant_d;
            cap_data  <= cap_data_d;
            cap_en    <= cap_en_d;
            ack       <= ack_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    cap_reg #(.W(W)) u_cap_reg (
        .ck       (ck),
        .rst_n    (rst_n),
        .cap_en   (cap_en),
        .cap_data (cap_data),
        .q        (out_q)
    );

    assign bus.ack       = ack;
    assign bus.grant_id  = grant;
    assign bus.busy      = busy;
    assign bus.cap_en    = cap_en;
    assign bus.cap_data  = cap_data;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_capture_scheduler.sv
// Directed, table-driven bench for capture_scheduler (NREQ=4, W=8).
module tb_capture_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;

    logic ck    = 1'b0;
    logic rst_n = 1'b0;

    capture_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

    capture_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 ck = ~ck;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] din;
        logic        busy;
        logic        cap_en;
        logic [3:0]  ack;
        logic        ov;
        logic [2:0]  gid;
        logic [7:0]  cd;
        logic [7:0]  out;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic busy, input logic ce, input logic [3:0] ack,
                           input logic ov, input logic [2:0] gid, input logic [7:0] cd,
                           input logic [7:0] out);
        chk({tag, ".busy"},      32'(bus.busy),      32'(busy));
        chk({tag, ".cap_en"},    32'(bus.cap_en),    32'(ce));
        chk({tag, ".ack"},       32'(bus.ack),       32'(ack));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".grant_id"},  32'(bus.grant_id),  32'(gid));
        chk({tag, ".cap_data"},  32'(bus.cap_data),  32'(cd));
        chk({tag, ".out"},       32'(bus.out),       32'(out));
    endtask

    // Inputs applied before a rising edge; outputs sampled on the following falling edge
    task automatic step(input logic [3:0] req, input logic [31:0] din);
        bus.req     = req;
        bus.data_in = din;
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.data_in = '0;
        @(negedge ck);
        chk_all("reset", 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 8'h00, 8'h00);
        rst_n = 1'b1;
    endtask

    // One full transaction: SETUP, CAPTURE, HOLD, back to IDLE
    function automatic void add_txn(input logic rst, input logic [3:0] req, input logic [3:0] req_last,
                                    input logic [31:0] din, input logic [2:0] gid,
                                    input logic [7:0] cd, input logic [7:0] prev_out);
        logic [3:0] ack_exp;
        ack_exp = 4'b0001 << gid;
        vecs.push_back('{rst, req,      din, 1'b1, 1'b0, 4'h0,    1'b0, gid, cd, prev_out});
        vecs.push_back('{1'b0, req,     din, 1'b1, 1'b1, 4'h0,    1'b0, gid, cd, prev_out});
        vecs.push_back('{1'b0, req,     din, 1'b1, 1'b0, ack_exp, 1'b1, gid, cd, cd});
        vecs.push_back('{1'b0, req_last, din, 1'b0, 1'b0, 4'h0,   1'b0, gid, cd, cd});
    endfunction

    initial begin
        bus.req     = '0;
        bus.data_in = '0;

        add_txn(1'b1, 4'b0001, 4'b0000, 32'h0000_00A5, 3'd0, 8'hA5, 8'h00);
        add_txn(1'b1, 4'b1111, 4'b1111, 32'h1312_1110, 3'd0, 8'h10, 8'h00);
        add_txn(1'b0, 4'b1111, 4'b1111, 32'h1312_1110, 3'd1, 8'h11, 8'h10);
        add_txn(1'b0, 4'b1111, 4'b1111, 32'h1312_1110, 3'd2, 8'h12, 8'h11);
        add_txn(1'b0, 4'b1111, 4'b1111, 32'h1312_1110, 3'd3, 8'h13, 8'h12);
        add_txn(1'b0, 4'b1111, 4'b0000, 32'h1312_1110, 3'd0, 8'h10, 8'h13);

        @(negedge ck);
        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            step(vecs[k].req, vecs[k].din);
            chk_all($sformatf("vec%0d", k), vecs[k].busy, vecs[k].cap_en, vecs[k].ack,
                    vecs[k].ov, vecs[k].gid, vecs[k].cd, vecs[k].out);
        end

        // Wrap-around: 3 wins, then 0 ahead of 3, then 3 again
        do_reset();
        step(4'b1000, 32'hD0C0_B0A0);
        chk("wrap.first", 32'(bus.grant_id), 32'd3);
        step(4'b1000, 32'hD0C0_B0A0);
        step(4'b1000, 32'hD0C0_B0A0);
        chk("wrap.ack3", 32'(bus.ack), 32'h8);
        step(4'b1001, 32'hD0C0_B0A0);
        step(4'b1001, 32'hD0C0_B0A0);
        chk("wrap.to0", 32'(bus.grant_id), 32'd0);
        chk("wrap.cd0", 32'(bus.cap_data), 32'hA0);
        step(4'b1001, 32'hD0C0_B0A0);
        step(4'b1001, 32'hD0C0_B0A0);
        chk("wrap.ack0", 32'(bus.ack), 32'h1);
        step(4'b1001, 32'hD0C0_B0A0);
        step(4'b1001, 32'hD0C0_B0A0);
        chk("wrap.back3", 32'(bus.grant_id), 32'd3);
        chk("wrap.cd3", 32'(bus.cap_data), 32'hD0);

        // Data changing after grant must not reach the capture register
        do_reset();
        step(4'b0001, 32'h0000_003C);
        step(4'b0001, 32'h0000_00FF);
        chk("late_data.cap_data", 32'(bus.cap_data), 32'h3C);
        step(4'b0001, 32'h0000_00FF);
        chk("late_data.out", 32'(bus.out), 32'h3C);
        chk("late_data.ov", 32'(bus.out_valid), 32'd1);
        step(4'b0000, 32'h0000_00FF);
        chk("late_data.idle_out", 32'(bus.out), 32'h3C);

        // Reset during CAPTURE aborts the transaction immediately
        do_reset();
        step(4'b0001, 32'h0000_0055);
        step(4'b0001, 32'h0000_0055);
        chk("abort.in_capture", 32'(bus.cap_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all("abort.now", 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge ck);
        chk("abort.no_ack", 32'(bus.ack), 32'h0);
        chk("abort.out", 32'(bus.out), 32'h0);
        rst_n = 1'b1;
        step(4'b0110, 32'h4433_2211);
        chk("abort.regrant", 32'(bus.grant_id), 32'd1);
        chk("abort.cd", 32'(bus.cap_data), 32'h22);
        step(4'b0110, 32'h4433_2211);
        step(4'b0110, 32'h4433_2211);
        chk("abort.ack1", 32'(bus.ack), 32'h2);

        // Request dropped during SETUP still completes
        do_reset();
        step(4'b0100, 32'h0077_0000);
        chk("drop.grant", 32'(bus.grant_id), 32'd2);
        step(4'b0000, 32'h0000_0000);
        step(4'b0000, 32'h0000_0000);
        chk_all("drop.hold", 1'b1, 1'b0, 4'b0100, 1'b1, 3'd2, 8'h77, 8'h77);
        step(4'b0000, 32'h0000_0000);
        step(4'b0000, 32'h0000_0000);
        chk_all("idle.keep", 1'b0, 1'b0, 4'h0, 1'b0, 3'd2, 8'h77, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
